// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: one signed MAC walks every (neuron, input) pair
// against a runtime-writable weight/bias store, with valid/ready handshakes on both sides.
module dense_layer_seq #(
    parameter int N_IN      = 8,
    parameter int N_OUT     = 8,
    parameter int DW        = 8,
    parameter int OW        = 16,
    parameter int ACC_W     = 24,
    parameter int OUT_SHIFT = 0,
    parameter int USE_RELU  = 1,
    parameter int AW        = $clog2(N_OUT * N_IN + N_OUT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*DW-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_OUT*OW-1:0]   out_data,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_data,
    output logic                  busy
);
    localparam int NW    = N_OUT * N_IN;
    localparam int NCOEF = NW + N_OUT;
    localparam int ICW   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int OCW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [AW-1:0]          BIAS_BASE  = AW'(NW);
    localparam logic [AW:0]            COEF_LIMIT = (AW+1)'(NCOEF);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((1 << (OW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state;
    logic signed [DW-1:0]     coef  [NCOEF];
    logic signed [DW-1:0]     x_arr [N_IN];
    logic signed [OW-1:0]     y_arr [N_OUT];
    logic [ICW-1:0]           i_cnt;
    logic [OCW-1:0]           o_cnt;
    logic [AW-1:0]            w_addr;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [2*DW-1:0]   prod;
    logic signed [OW-1:0]     y_new;
    logic                     wr_ok;

    // A write is honoured only while idle and not colliding with an input accept.
    assign wr_ok = wr_en && (state == IDLE) && !in_valid && ({1'b0, wr_addr} < COEF_LIMIT);

    // NOTE: the coefficient store is deliberately left out of reset so loaded weights survive it.
    always_ff @(posedge clk) begin
        if (wr_ok) coef[wr_addr] <= wr_data;
    end

    // NOTE: every always_comb output is assigned a default first so no latch is inferred.
    always_comb begin
        prod     = x_arr[i_cnt] * coef[w_addr];
        acc_next = acc + ACC_W'(prod);
        shifted  = acc_next >>> OUT_SHIFT;
        y_new    = OW'(shifted);
        if (shifted > SAT_MAX)      y_new = OW'(SAT_MAX);
        else if (shifted < SAT_MIN) y_new = OW'(SAT_MIN);
        if (USE_RELU != 0 && y_new[OW-1]) y_new = '0;
    end

    always_comb begin
        out_data = '0;
        for (int g = 0; g < N_OUT; g++) out_data[g*OW +: OW] = y_arr[g];
    end

    // NOTE: state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            i_cnt     <= '0;
            o_cnt     <= '0;
            w_addr    <= '0;
            acc       <= '0;
            for (int k = 0; k < N_IN; k++)  x_arr[k] <= '0;
            for (int k = 0; k < N_OUT; k++) y_arr[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < N_IN; k++) x_arr[k] <= in_data[k*DW +: DW];
                        i_cnt    <= '0;
                        o_cnt    <= '0;
                        w_addr   <= '0;
                        acc      <= ACC_W'(coef[BIAS_BASE]);
                        state    <= MAC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MAC: begin
                    // Weights are stored neuron-major, so the flat address simply advances.
                    w_addr <= w_addr + AW'(1);
                    if (i_cnt == ICW'(N_IN - 1)) begin
                        y_arr[o_cnt] <= y_new;
                        i_cnt        <= '0;
                        if (o_cnt == OCW'(N_OUT - 1)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            o_cnt <= o_cnt + OCW'(1);
                            acc   <= ACC_W'(coef[BIAS_BASE + AW'(o_cnt) + AW'(1)]);
                        end
                    end else begin
                        acc   <= acc_next;
                        i_cnt <= i_cnt + ICW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: 8x8 ReLU and linear instances driven in lockstep, plus a
// 1-input/3-neuron instance with a shift and a narrow output.
module tb_dense_layer_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, out_ready, wr_en;
    logic [63:0]  in_data;
    logic [6:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         in_ready_r, out_valid_r, busy_r;
    logic         in_ready_l, out_valid_l, busy_l;
    logic [127:0] out_data_r, out_data_l;

    logic         s_in_valid, s_out_ready, s_wr_en;
    logic [7:0]   s_in_data, s_wr_data;
    logic [2:0]   s_wr_addr;
    logic         s_in_ready, s_out_valid, s_busy;
    logic [23:0]  s_out_data;

    dense_layer_seq #(.USE_RELU(1)) dut_r (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_data(in_data), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy_r));

    dense_layer_seq #(.USE_RELU(0)) dut_l (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_data(out_data_l), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy_l));

    dense_layer_seq #(.N_IN(1), .N_OUT(3), .OW(8), .ACC_W(18), .OUT_SHIFT(2), .USE_RELU(0)) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .busy(s_busy));

    int checks = 0;
    int errors = 0;
    int w_m [8][8];
    int b_m [8];
    int x_m [8];

    typedef struct {
        int x  [8];
        int er [8];
        int el [8];
    } vec_t;
    vec_t tbl [3];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: bias plus dot product, floor-shift, clamp to the output range, optional ReLU.
    function automatic int model_y(int o, int n_in, int shift, int ow, bit relu);
        int s;
        int hi;
        int lo;
        s = b_m[o];
        for (int i = 0; i < n_in; i++) s += x_m[i] * w_m[o][i];
        s = s >>> shift;
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    function automatic int yr(int o);
        logic signed [15:0] t;
        t = out_data_r[o*16 +: 16];
        return int'(t);
    endfunction

    function automatic int yl(int o);
        logic signed [15:0] t;
        t = out_data_l[o*16 +: 16];
        return int'(t);
    endfunction

    function automatic int ys(int o);
        logic signed [7:0] t;
        t = s_out_data[o*8 +: 8];
        return int'(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 7'(a);
        wr_data = 8'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_big();
        for (int o = 0; o < 8; o++)
            for (int i = 0; i < 8; i++) wr(o * 8 + i, w_m[o][i]);
        for (int o = 0; o < 8; o++) wr(64 + o, b_m[o]);
    endtask

    task automatic set_identity();
        for (int o = 0; o < 8; o++) begin
            for (int i = 0; i < 8; i++) w_m[o][i] = (o == i) ? 1 : 0;
            b_m[o] = o;
        end
        load_big();
    endtask

    task automatic fill_all(input int w, input int b, input int x);
        for (int o = 0; o < 8; o++) begin
            for (int i = 0; i < 8; i++) w_m[o][i] = w;
            b_m[o] = b;
            x_m[o] = x;
        end
        load_big();
    endtask

    task automatic start_big();
        check("in_ready before accept", int'(in_ready_r), 1);
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(x_m[i]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_big(input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid_r && lat < 300) begin
            tick();
            lat++;
        end
        check("latency to out_valid", lat, exp_lat);
        check("linear out_valid", int'(out_valid_l), 1);
    endtask

    task automatic done_big();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_row(input string tag, input int er [8], input int el [8]);
        for (int o = 0; o < 8; o++) begin
            check($sformatf("%s relu y%0d", tag, o), yr(o), er[o]);
            check($sformatf("%s lin y%0d", tag, o), yl(o), el[o]);
        end
    endtask

    task automatic s_wr(input int a, input int d);
        s_wr_en   = 1'b1;
        s_wr_addr = 3'(a);
        s_wr_data = 8'(d);
        tick();
        s_wr_en = 1'b0;
    endtask

    task automatic s_run();
        int lat;
        for (int o = 0; o < 3; o++) begin
            s_wr(o, w_m[o][0]);
            s_wr(3 + o, b_m[o]);
        end
        check("small in_ready", int'(s_in_ready), 1);
        s_in_data  = 8'(x_m[0]);
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("small latency", lat, 3);
    endtask

    task automatic s_done();
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] snap;
        int er [8];
        int el [8];

        tbl[0].x  = '{10, 20, 30, 40, 50, 60, 70, 80};
        tbl[0].er = '{10, 21, 32, 43, 54, 65, 76, 87};
        tbl[0].el = '{10, 21, 32, 43, 54, 65, 76, 87};
        tbl[1].x  = '{-3, -3, -3, -3, -3, -3, -3, -3};
        tbl[1].er = '{0, 0, 0, 0, 1, 2, 3, 4};
        tbl[1].el = '{-3, -2, -1, 0, 1, 2, 3, 4};
        tbl[2].x  = '{127, -128, 0, 1, -1, 100, -100, 5};
        tbl[2].er = '{127, 0, 2, 4, 3, 105, 0, 12};
        tbl[2].el = '{127, -127, 2, 4, 3, 105, -94, 12};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; wr_en = 1'b0;
        in_data = '0; wr_addr = '0; wr_data = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_wr_en = 1'b0;
        s_in_data = '0; s_wr_addr = '0; s_wr_data = '0;
        tick();
        tick();
        check("reset in_ready", int'(in_ready_r), 1);
        check("reset out_valid", int'(out_valid_r), 0);
        check("reset busy", int'(busy_r), 0);
        check("reset out_data", int'(|out_data_r), 0);
        check("reset small in_ready", int'(s_in_ready), 1);
        reset = 1'b0;

        // Identity weights, table-driven vectors.
        set_identity();
        for (int r = 0; r < 3; r++) begin
            x_m = tbl[r].x;
            start_big();
            check("busy during MAC", int'(busy_r), 1);
            wait_big(64);
            check_row($sformatf("ident%0d", r), tbl[r].er, tbl[r].el);
            done_big();
        end

        // Write during MAC cycle 10 is dropped.
        x_m = tbl[0].x;
        start_big();
        repeat (9) tick();
        wr(0, 5);
        wait_big(54);
        check_row("busy write", tbl[0].er, tbl[0].el);
        done_big();

        // Write coinciding with an accept is dropped; out-of-range write in IDLE is dropped.
        wr(100, 50);
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(tbl[0].x[i]);
        in_valid = 1'b1; wr_en = 1'b1; wr_addr = 7'd0; wr_data = 8'd9;
        tick();
        in_valid = 1'b0; wr_en = 1'b0;
        wait_big(64);
        check_row("accept write", tbl[0].er, tbl[0].el);
        done_big();
        start_big();
        wait_big(64);
        check_row("readback", tbl[0].er, tbl[0].el);

        // Backpressure: hold out_ready low while pulsing in_valid.
        snap = out_data_r;
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            in_data  = {$urandom, $urandom};
            tick();
            check("backpressure hold {in_ready,busy,out_valid,stable}",
                  int'({in_ready_r, busy_r, out_valid_r, out_data_r == snap}), 7);
        end
        in_valid = 1'b0;
        done_big();
        check("post handshake in_ready", int'(in_ready_r), 1);
        check("post handshake out_valid", int'(out_valid_r), 0);
        check("post handshake busy", int'(busy_r), 0);
        check("out_data held after handshake", int'(out_data_r == snap), 1);

        // Negative sum -136.
        fill_all(1, -128, -1);
        start_big();
        wait_big(64);
        er = '{0, 0, 0, 0, 0, 0, 0, 0};
        el = '{-136, -136, -136, -136, -136, -136, -136, -136};
        check_row("negative", er, el);
        done_big();

        // Positive and negative saturation.
        fill_all(-128, 127, -128);
        start_big();
        wait_big(64);
        er = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        check_row("sat high", er, er);
        done_big();
        fill_all(127, -128, -128);
        start_big();
        wait_big(64);
        er = '{0, 0, 0, 0, 0, 0, 0, 0};
        el = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        check_row("sat low", er, el);
        done_big();

        // Randomized coefficients and inputs against the reference.
        for (int n = 0; n < 4; n++) begin
            for (int o = 0; o < 8; o++) begin
                for (int i = 0; i < 8; i++) w_m[o][i] = int'($urandom_range(255)) - 128;
                b_m[o] = int'($urandom_range(255)) - 128;
                x_m[o] = int'($urandom_range(255)) - 128;
            end
            load_big();
            start_big();
            wait_big(64);
            for (int o = 0; o < 8; o++) begin
                er[o] = model_y(o, 8, 0, 16, 1'b1);
                el[o] = model_y(o, 8, 0, 16, 1'b0);
            end
            check_row($sformatf("random%0d", n), er, el);
            done_big();
        end

        // Reset at MAC cycle 30 aborts; coefficients survive.
        set_identity();
        x_m = tbl[0].x;
        start_big();
        repeat (29) tick();
        reset = 1'b1;
        tick();
        check("mid reset out_valid", int'(out_valid_r), 0);
        check("mid reset busy", int'(busy_r), 0);
        check("mid reset in_ready", int'(in_ready_r), 1);
        check("mid reset out_data", int'(|out_data_r), 0);
        reset = 1'b0;
        start_big();
        wait_big(64);
        check_row("after reset", tbl[0].er, tbl[0].el);
        done_big();

        // Single-input, three-neuron instance: floor shift and 8-bit saturation.
        w_m[0][0] = -1;   b_m[0] = -128;
        w_m[1][0] = 127;  b_m[1] = 127;
        w_m[2][0] = -128; b_m[2] = -128;
        x_m[0] = 127;
        s_run();
        check("small y0 floor", ys(0), -64);
        check("small y1 sat", ys(1), 127);
        check("small y2 sat", ys(2), -128);
        s_done();
        for (int n = 0; n < 5; n++) begin
            for (int o = 0; o < 3; o++) begin
                w_m[o][0] = int'($urandom_range(255)) - 128;
                b_m[o]    = int'($urandom_range(255)) - 128;
            end
            x_m[0] = int'($urandom_range(255)) - 128;
            s_run();
            for (int o = 0; o < 3; o++)
                check($sformatf("small random%0d y%0d", n, o), ys(o), model_y(o, 1, 2, 8, 1'b0));
            s_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
